// File: rtl/weight_stream_replayer.sv
`default_nettype none
// ============================================================================
// Module   : weight_stream_replayer
// Purpose  : Captures one weight set from a load AXI-stream into on-chip
//            memory, then replays it a programmed number of passes on an
//            output AXI-stream through a 2-entry skid buffer.
// Revision : 1.0  initial release
// ============================================================================
module weight_stream_replayer #(
    parameter  int WEIGHT_WIDTH = 8,
    parameter  int MEM_DEPTH    = 256,
    parameter  int REPS_WIDTH   = 16,
    localparam int c_AW         = $clog2(MEM_DEPTH + 1)
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic [c_AW-1:0]         cfg_count,
    input  logic [REPS_WIDTH-1:0]   cfg_reps,
    input  logic                    load_start,
    input  logic                    start,
    output logic                    busy,
    output logic                    loaded,
    output logic                    done,
    output logic                    cfg_err,
    input  logic [WEIGHT_WIDTH-1:0] s_axis_wload_tdata,
    input  logic                    s_axis_wload_tvalid,
    output logic                    s_axis_wload_tready,
    output logic [WEIGHT_WIDTH-1:0] m_axis_weights_tdata,
    output logic                    m_axis_weights_tvalid,
    input  logic                    m_axis_weights_tready
);

    // Pointers only ever address 0..MEM_DEPTH-1, so they use the index width.
    localparam int                    c_IW       = $clog2(MEM_DEPTH);
    localparam logic [c_AW-1:0]       c_DEPTH    = c_AW'(MEM_DEPTH);
    localparam logic [c_AW-1:0]       c_CNT_ONE  = c_AW'(1);
    localparam logic [c_IW-1:0]       c_PTR_ONE  = c_IW'(1);
    localparam logic [REPS_WIDTH-1:0] c_REP_ONE  = REPS_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_LOADED = 2'd2,
        ST_STREAM = 2'd3
    } state_t;

    state_t                  r_state_q,      w_state_d;
    logic [c_IW-1:0]         r_cnt_m1_q,     w_cnt_m1_d;
    logic [c_IW-1:0]         r_wr_ptr_q,     w_wr_ptr_d;
    logic [c_IW-1:0]         r_rd_ptr_q,     w_rd_ptr_d;
    logic [REPS_WIDTH-1:0]   r_rep_q,        w_rep_d;
    logic [REPS_WIDTH-1:0]   r_reps_q,       w_reps_d;
    logic                    r_iss_done_q,   w_iss_done_d;
    logic [WEIGHT_WIDTH-1:0] r_buf0_q,       w_buf0_d;
    logic [WEIGHT_WIDTH-1:0] r_buf1_q,       w_buf1_d;
    logic [1:0]              r_buf_cnt_q,    w_buf_cnt_d;
    logic                    r_loaded_q,     w_loaded_d;
    logic                    r_done_q,       w_done_d;
    logic                    r_cfg_err_q,    w_cfg_err_d;
    logic                    r_busy_q,       w_busy_d;
    logic                    r_tready_q,     w_tready_d;

    logic [WEIGHT_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [WEIGHT_WIDTH-1:0] w_rd_word;
    logic                    w_wr_en;
    logic                    w_issue;
    logic                    w_pop;
    logic                    w_cfg_ok;

    assign w_rd_word = r_mem[r_rd_ptr_q];
    assign w_pop     = (r_buf_cnt_q != 2'd0) && m_axis_weights_tready;
    assign w_cfg_ok  = (cfg_count != '0) && (cfg_count <= c_DEPTH);

    // Next-state logic for the controller, read pointers and skid buffer.
    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_m1_d   = r_cnt_m1_q;
        w_wr_ptr_d   = r_wr_ptr_q;
        w_rd_ptr_d   = r_rd_ptr_q;
        w_rep_d      = r_rep_q;
        w_reps_d     = r_reps_q;
        w_iss_done_d = r_iss_done_q;
        w_buf0_d     = r_buf0_q;
        w_buf1_d     = r_buf1_q;
        w_buf_cnt_d  = r_buf_cnt_q;
        w_loaded_d   = r_loaded_q;
        w_done_d     = 1'b0;
        w_cfg_err_d  = 1'b0;
        w_wr_en      = 1'b0;
        w_issue      = 1'b0;

        case (r_state_q)
            ST_IDLE, ST_LOADED: begin
                // load_start has priority over start when both arrive together.
                if (load_start) begin
                    if (w_cfg_ok) begin
                        w_state_d  = ST_LOAD;
                        w_wr_ptr_d = '0;
                        w_cnt_m1_d = c_IW'(cfg_count - c_CNT_ONE);
                        w_loaded_d = 1'b0;
                    end else begin
                        w_cfg_err_d = 1'b1;
                    end
                end else if (start && (r_state_q == ST_LOADED)) begin
                    if (cfg_reps == '0) begin
                        w_done_d = 1'b1;
                    end else begin
                        w_reps_d     = cfg_reps;
                        w_rd_ptr_d   = '0;
                        w_rep_d      = '0;
                        w_iss_done_d = 1'b0;
                        w_state_d    = ST_STREAM;
                    end
                end
            end
            ST_LOAD: begin
                if (s_axis_wload_tvalid && r_tready_q) begin
                    w_wr_en    = 1'b1;
                    w_wr_ptr_d = r_wr_ptr_q + c_PTR_ONE;
                    if (r_wr_ptr_q == r_cnt_m1_q) begin
                        w_state_d  = ST_LOADED;
                        w_loaded_d = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                // A read may land only where a slot is free after this cycle's pop.
                w_issue = !r_iss_done_q && ((r_buf_cnt_q != 2'd2) || w_pop);
                if (w_issue) begin
                    if (r_rd_ptr_q == r_cnt_m1_q) begin
                        w_rd_ptr_d = '0;
                        if (r_rep_q == (r_reps_q - c_REP_ONE)) begin
                            w_iss_done_d = 1'b1;
                        end else begin
                            w_rep_d = r_rep_q + c_REP_ONE;
                        end
                    end else begin
                        w_rd_ptr_d = r_rd_ptr_q + c_PTR_ONE;
                    end
                end
                // Final beat: all words issued and only the head entry remains.
                if (r_iss_done_q && w_pop && (r_buf_cnt_q == 2'd1)) begin
                    w_state_d = ST_LOADED;
                    w_done_d  = 1'b1;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase

        // Skid buffer: buf0 is the presented head, buf1 the overflow slot.
        case ({w_issue, w_pop})
            2'b10: begin
                if (r_buf_cnt_q == 2'd0) w_buf0_d = w_rd_word;
                else                     w_buf1_d = w_rd_word;
                w_buf_cnt_d = r_buf_cnt_q + 2'd1;
            end
            2'b01: begin
                w_buf0_d    = r_buf1_q;
                w_buf_cnt_d = r_buf_cnt_q - 2'd1;
            end
            2'b11: begin
                if (r_buf_cnt_q == 2'd1) begin
                    w_buf0_d = w_rd_word;
                end else begin
                    w_buf0_d = r_buf1_q;
                    w_buf1_d = w_rd_word;
                end
            end
            default: ;
        endcase

        w_busy_d   = (w_state_d == ST_LOAD) || (w_state_d == ST_STREAM);
        w_tready_d = (w_state_d == ST_LOAD);
    end

    // Controller, buffer and status registers with synchronous reset.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state_q    <= ST_IDLE;
            r_cnt_m1_q   <= '0;
            r_wr_ptr_q   <= '0;
            r_rd_ptr_q   <= '0;
            r_rep_q      <= '0;
            r_reps_q     <= '0;
            r_iss_done_q <= 1'b0;
            r_buf0_q     <= '0;
            r_buf1_q     <= '0;
            r_buf_cnt_q  <= 2'd0;
            r_loaded_q   <= 1'b0;
            r_done_q     <= 1'b0;
            r_cfg_err_q  <= 1'b0;
            r_busy_q     <= 1'b0;
            r_tready_q   <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_m1_q   <= w_cnt_m1_d;
            r_wr_ptr_q   <= w_wr_ptr_d;
            r_rd_ptr_q   <= w_rd_ptr_d;
            r_rep_q      <= w_rep_d;
            r_reps_q     <= w_reps_d;
            r_iss_done_q <= w_iss_done_d;
            r_buf0_q     <= w_buf0_d;
            r_buf1_q     <= w_buf1_d;
            r_buf_cnt_q  <= w_buf_cnt_d;
            r_loaded_q   <= w_loaded_d;
            r_done_q     <= w_done_d;
            r_cfg_err_q  <= w_cfg_err_d;
            r_busy_q     <= w_busy_d;
            r_tready_q   <= w_tready_d;
        end
    end

    // Weight memory write port; contents survive reset by design.
    always_ff @(posedge ap_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr_q] <= s_axis_wload_tdata;
        end
    end

    assign busy                  = r_busy_q;
    assign loaded                = r_loaded_q;
    assign done                  = r_done_q;
    assign cfg_err               = r_cfg_err_q;
    assign s_axis_wload_tready   = r_tready_q;
    assign m_axis_weights_tdata  = r_buf0_q;
    assign m_axis_weights_tvalid = (r_buf_cnt_q != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_weight_stream_replayer.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_stream_replayer
// Purpose  : Directed self-checking bench for weight_stream_replayer.
// Revision : 1.0  initial release
// ============================================================================
module tb_weight_stream_replayer;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [8:0]  cfg_count;
    logic [15:0] cfg_reps;
    logic        load_start;
    logic        start;
    logic        busy;
    logic        loaded;
    logic        done;
    logic        cfg_err;
    logic [7:0]  s_axis_wload_tdata;
    logic        s_axis_wload_tvalid;
    logic        s_axis_wload_tready;
    logic [7:0]  m_axis_weights_tdata;
    logic        m_axis_weights_tvalid;
    logic        m_axis_weights_tready;

    int n_tests = 0;
    int n_fail  = 0;

    weight_stream_replayer #(
        .WEIGHT_WIDTH (8),
        .MEM_DEPTH    (256),
        .REPS_WIDTH   (16)
    ) dut (
        .ap_clk                (ap_clk),
        .ap_rst                (ap_rst),
        .cfg_count             (cfg_count),
        .cfg_reps              (cfg_reps),
        .load_start            (load_start),
        .start                 (start),
        .busy                  (busy),
        .loaded                (loaded),
        .done                  (done),
        .cfg_err               (cfg_err),
        .s_axis_wload_tdata    (s_axis_wload_tdata),
        .s_axis_wload_tvalid   (s_axis_wload_tvalid),
        .s_axis_wload_tready   (s_axis_wload_tready),
        .m_axis_weights_tdata  (m_axis_weights_tdata),
        .m_axis_weights_tvalid (m_axis_weights_tvalid),
        .m_axis_weights_tready (m_axis_weights_tready)
    );

    always #5 ap_clk = ~ap_clk;

    // Advance one cycle; inputs are driven and outputs sampled at the negedge.
    task automatic tick();
        @(posedge ap_clk);
        @(negedge ap_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-written expected word tables for each directed set.
    function automatic logic [7:0] exp_word(input int mode, input int b);
        case (mode)
            0:       return 8'(8'h11 * ((b % 4) + 1));
            1:       return 8'(b % 256);
            default: return (b % 2 == 0) ? 8'h5A : 8'hA5;
        endcase
    endfunction

    task automatic begin_load(input logic [8:0] n);
        cfg_count  = n;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] d);
        s_axis_wload_tdata  = d;
        s_axis_wload_tvalid = 1'b1;
        tick();
        s_axis_wload_tvalid = 1'b0;
    endtask

    // Full-rate replay: first beat two cycles after start, then back-to-back.
    task automatic run_stream(input int n, input logic [15:0] reps, input int mode, input string tag);
        m_axis_weights_tready = 1'b1;
        cfg_reps = reps;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_lat_tvalid"}, 32'(m_axis_weights_tvalid), 32'd0);
        tick();
        for (int b = 0; b < n * int'(reps); b++) begin
            check({tag, "_tvalid"}, 32'(m_axis_weights_tvalid), 32'd1);
            check({tag, "_tdata"},  32'(m_axis_weights_tdata),  32'(exp_word(mode, b)));
            tick();
        end
        check({tag, "_done"},      32'(done),                  32'd1);
        check({tag, "_end_tvalid"}, 32'(m_axis_weights_tvalid), 32'd0);
        check({tag, "_loaded"},    32'(loaded),                32'd1);
        tick();
        check({tag, "_done_clr"},  32'(done),                  32'd0);
    endtask

    initial begin
        logic [31:0] pat;
        logic [7:0]  held;
        int          idx;
        int          dones;
        logic        stalled;

        ap_rst = 1'b1; cfg_count = '0; cfg_reps = '0; load_start = 1'b0; start = 1'b0;
        s_axis_wload_tdata = '0; s_axis_wload_tvalid = 1'b0; m_axis_weights_tready = 1'b0;
        @(negedge ap_clk);
        repeat (3) tick();
        check("rst_busy",    32'(busy),                  32'd0);
        check("rst_loaded",  32'(loaded),                32'd0);
        check("rst_done",    32'(done),                  32'd0);
        check("rst_cfg_err", 32'(cfg_err),               32'd0);
        check("rst_tready",  32'(s_axis_wload_tready),   32'd0);
        check("rst_tvalid",  32'(m_axis_weights_tvalid), 32'd0);
        check("rst_tdata",   32'(m_axis_weights_tdata),  32'd0);
        ap_rst = 1'b0;
        tick();

        // Invalid counts: zero and MEM_DEPTH+1.
        begin_load(9'd0);
        check("err0_pulse",  32'(cfg_err),             32'd1);
        check("err0_loaded", 32'(loaded),              32'd0);
        check("err0_tready", 32'(s_axis_wload_tready), 32'd0);
        tick();
        check("err0_clr",    32'(cfg_err),             32'd0);
        begin_load(9'd257);
        check("err257_pulse",  32'(cfg_err),             32'd1);
        check("err257_tready", 32'(s_axis_wload_tready), 32'd0);
        tick();
        check("err257_clr",    32'(cfg_err),             32'd0);
        check("err257_busy",   32'(busy),                32'd0);

        // Start in IDLE is ignored.
        cfg_reps = 16'd1; start = 1'b1; tick(); start = 1'b0; tick();
        check("idle_start_tvalid", 32'(m_axis_weights_tvalid), 32'd0);

        // Four-word set.
        begin_load(9'd4);
        check("load4_tready", 32'(s_axis_wload_tready), 32'd1);
        check("load4_busy",   32'(busy),                32'd1);
        push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
        check("load4_loaded", 32'(loaded),              32'd1);
        check("load4_tready_off", 32'(s_axis_wload_tready), 32'd0);
        check("load4_busy_off",   32'(busy),            32'd0);

        run_stream(4, 16'd3, 0, "rep3");

        // Same replay under a fixed pseudo-random 50% tready pattern.
        pat = 32'b1011_0010_1110_0101_0100_1100_1001_1101;
        idx = 0; dones = 0; stalled = 1'b0; held = '0;
        cfg_reps = 16'd3; start = 1'b1; m_axis_weights_tready = 1'b0; tick(); start = 1'b0;
        for (int c = 0; c < 120; c++) begin
            m_axis_weights_tready = pat[c % 32];
            if (stalled) begin
                check("stall_hold_valid", 32'(m_axis_weights_tvalid), 32'd1);
                check("stall_hold_data",  32'(m_axis_weights_tdata),  32'(held));
            end
            if (done) dones++;
            if (m_axis_weights_tvalid && m_axis_weights_tready) begin
                if (idx < 12) check("stall_tdata", 32'(m_axis_weights_tdata), 32'(exp_word(0, idx)));
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = m_axis_weights_tvalid;
                held    = m_axis_weights_tdata;
            end
            tick();
        end
        check("stall_beats",  32'(idx),    32'd12);
        check("stall_dones",  32'(dones),  32'd1);
        check("stall_loaded", 32'(loaded), 32'd1);

        // Zero passes: done next cycle, set retained.
        cfg_reps = 16'd0; start = 1'b1; tick(); start = 1'b0;
        check("rep0_done",   32'(done),                  32'd1);
        check("rep0_tvalid", 32'(m_axis_weights_tvalid), 32'd0);
        check("rep0_loaded", 32'(loaded),                32'd1);
        check("rep0_busy",   32'(busy),                  32'd0);
        tick();
        check("rep0_done_clr", 32'(done), 32'd0);

        // Full-depth ramp, loaded with gaps in tvalid.
        begin_load(9'd256);
        for (int i = 0; i < 256; i++) begin
            push_word(8'(i));
            tick();
        end
        check("ramp_loaded", 32'(loaded), 32'd1);
        run_stream(256, 16'd2, 1, "ramp");

        // Reset while beat 5 is presented.
        m_axis_weights_tready = 1'b1;
        cfg_reps = 16'd1; start = 1'b1; tick(); start = 1'b0; tick();
        repeat (4) tick();
        check("mid_beat5", 32'(m_axis_weights_tdata), 32'd4);
        ap_rst = 1'b1; tick(); ap_rst = 1'b0;
        check("mid_rst_tvalid", 32'(m_axis_weights_tvalid), 32'd0);
        check("mid_rst_loaded", 32'(loaded),                32'd0);
        check("mid_rst_busy",   32'(busy),                  32'd0);
        start = 1'b1; tick(); start = 1'b0; tick();
        check("mid_rst_start_ignored", 32'(m_axis_weights_tvalid), 32'd0);
        check("mid_rst_start_busy",    32'(busy),                  32'd0);

        // Reload, then load_start together with start: load wins.
        begin_load(9'd2);
        push_word(8'h01); push_word(8'h02);
        check("reload_loaded", 32'(loaded), 32'd1);
        cfg_count = 9'd2; load_start = 1'b1; start = 1'b1; tick();
        load_start = 1'b0; start = 1'b0;
        check("both_tready", 32'(s_axis_wload_tready), 32'd1);
        check("both_loaded", 32'(loaded),              32'd0);
        tick();
        check("both_tvalid", 32'(m_axis_weights_tvalid), 32'd0);
        push_word(8'h5A); push_word(8'hA5);
        run_stream(2, 16'd2, 2, "reload");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
